fmul_result_queue: RTL and testbench

//   Buffers fmul results (d, overflow, underflow) with their destination tag until register-file writeback accepts them.

---
 rtl/fmul_result_queue.sv | 134 +++++++++++++
 tb/tb_fmul_result_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fmul_result_queue.sv
// fmul_result_queue: small FIFO that holds fmul results (data, overflow,
// underflow) with their destination tag until writeback takes them. It also
// keeps sticky FPU exception flags that the CSR unit can read and clear.
// in_ready and out_valid come only from registered state. There is no path
// from the inputs straight through to the outputs.
module fmul_result_queue #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 5
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [TAG_W-1:0]             in_tag,
   input  logic [31:0]                  in_data,
   input  logic                         in_overflow,
   input  logic                         in_underflow,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [TAG_W-1:0]             out_tag,
   output logic [31:0]                  out_data,
   output logic                         out_overflow,
   output logic                         out_underflow,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         flag_overflow,
   output logic                         flag_underflow,
   output logic                         flag_invalid,
   input  logic                         flags_clear
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [31:0]      data;
      logic             ovf;
      logic             unf;
   } entry_t;

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             flag_ovf_q, flag_ovf_d;
   logic             flag_unf_q, flag_unf_d;
   logic             flag_inv_q, flag_inv_d;
   logic             push, pop, in_nan;
   entry_t           head;

   // Handshake status depends only on the registered occupancy count.
   assign in_ready  = (count_q != CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign in_nan    = (in_data[30:23] == 8'hFF) && (in_data[22:0] != '0);

   // Compute the next pointers, occupancy and sticky flags.
   always_comb begin
      // NOTE: every signal gets a default first, so no path through this block can infer a latch.
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      flag_ovf_d = flag_ovf_q;
      flag_unf_d = flag_unf_q;
      flag_inv_d = flag_inv_q;

      // The pointers are log2(DEPTH) bits wide, so they wrap modulo DEPTH
      // without extra logic.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // A clear in the same cycle as a push loses to the push: the push
      // still sets its own bits.
      if (flags_clear) begin
         flag_ovf_d = 1'b0;
         flag_unf_d = 1'b0;
         flag_inv_d = 1'b0;
      end
      if (push) begin
         flag_ovf_d = flag_ovf_d | in_overflow;
         flag_unf_d = flag_unf_d | in_underflow;
         flag_inv_d = flag_inv_d | in_nan;
      end
   end

   // Control state registers, with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples its pre-edge value.
      if (!rstn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         flag_ovf_q <= 1'b0;
         flag_unf_q <= 1'b0;
         flag_inv_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         flag_ovf_q <= flag_ovf_d;
         flag_unf_q <= flag_unf_d;
         flag_inv_q <= flag_inv_d;
      end
   end

   // Write the accepted result into the slot at the write pointer.
   always_ff @(posedge clk) begin
      // NOTE: storage is left out of reset on purpose; out_valid masks any stale entries.
      if (push) mem_q[wr_ptr_q] <= '{tag: in_tag, data: in_data, ovf: in_overflow, unf: in_underflow};
   end

   // Present the head entry, forced to zero while the queue is empty.
   always_comb begin
      head = '0;
      if (out_valid) head = mem_q[rd_ptr_q];
   end

   assign out_tag        = head.tag;
   assign out_data       = head.data;
   assign out_overflow   = head.ovf;
   assign out_underflow  = head.unf;
   assign count          = count_q;
   assign flag_overflow  = flag_ovf_q;
   assign flag_underflow = flag_unf_q;
   assign flag_invalid   = flag_inv_q;

endmodule

// File: tb/tb_fmul_result_queue.sv
// Testbench for fmul_result_queue. A scoreboard queue holds the expected
// entries. Each cycle the bench checks the DUT outputs against the model
// before the clock edge, then updates the model with the push and pop that
// the edge performs.
module tb_fmul_result_queue;

   localparam int DEPTH = 4;
   localparam int TAG_W = 5;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rstn;
   logic             in_valid, in_ready;
   logic [TAG_W-1:0] in_tag;
   logic [31:0]      in_data;
   logic             in_overflow, in_underflow;
   logic             out_valid, out_ready;
   logic [TAG_W-1:0] out_tag;
   logic [31:0]      out_data;
   logic             out_overflow, out_underflow;
   logic [CNT_W-1:0] count;
   logic             flag_overflow, flag_underflow, flag_invalid;
   logic             flags_clear;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [31:0]      data;
      logic             ovf;
      logic             unf;
   } ent_t;

   ent_t sb[$];
   logic m_fo, m_fu, m_fi;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   fmul_result_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_data(in_data),
      .in_overflow(in_overflow), .in_underflow(in_underflow),
      .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_data(out_data),
      .out_overflow(out_overflow), .out_underflow(out_underflow),
      .count(count), .flag_overflow(flag_overflow), .flag_underflow(flag_underflow),
      .flag_invalid(flag_invalid), .flags_clear(flags_clear)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic is_nan(input logic [31:0] d);
      return (d[30:23] == 8'hFF) && (d[22:0] != 23'd0);
   endfunction

   // Check outputs against the model, take one clock edge, then advance the model.
   task automatic step();
      bit   push, pop;
      ent_t e;
      check("in_ready",  in_ready,  sb.size() != DEPTH);
      check("out_valid", out_valid, sb.size() != 0);
      check("count",     count,     sb.size());
      if (sb.size() != 0) begin
         check("head_tag",  out_tag,       sb[0].tag);
         check("head_data", out_data,      sb[0].data);
         check("head_ovf",  out_overflow,  sb[0].ovf);
         check("head_unf",  out_underflow, sb[0].unf);
      end else begin
         check("empty_head", {out_tag, out_data, out_overflow, out_underflow}, 0);
      end
      check("flag_ovf", flag_overflow,  m_fo);
      check("flag_unf", flag_underflow, m_fu);
      check("flag_inv", flag_invalid,   m_fi);
      push = in_valid && (sb.size() != DEPTH);
      pop  = out_ready && (sb.size() != 0);
      e    = '{tag: in_tag, data: in_data, ovf: in_overflow, unf: in_underflow};
      @(posedge clk); #1;
      if (!rstn) begin
         sb.delete();
         m_fo = 1'b0; m_fu = 1'b0; m_fi = 1'b0;
      end else begin
         if (pop) void'(sb.pop_front());
         if (push) sb.push_back(e);
         if (flags_clear) begin m_fo = 1'b0; m_fu = 1'b0; m_fi = 1'b0; end
         if (push) begin
            m_fo = m_fo | e.ovf;
            m_fu = m_fu | e.unf;
            m_fi = m_fi | is_nan(e.data);
         end
      end
   endtask

   // Set up the inputs for one cycle and take it through step().
   task automatic cyc(input bit v, input logic [TAG_W-1:0] t, input logic [31:0] d,
                      input bit o, input bit u, input bit rdy, input bit clr);
      in_valid = v; in_tag = t; in_data = d; in_overflow = o; in_underflow = u;
      out_ready = rdy; flags_clear = clr;
      step();
   endtask

   task automatic idle(input bit rdy);
      cyc(1'b0, '0, 32'h0, 1'b0, 1'b0, rdy, 1'b0);
   endtask

   initial begin
      m_fo = 1'b0; m_fu = 1'b0; m_fi = 1'b0;

      // Reset with in_valid held high for two edges.
      rstn = 1'b0; in_valid = 1'b1; in_tag = 5'd7; in_data = 32'hDEADBEEF;
      in_overflow = 1'b1; in_underflow = 1'b1; out_ready = 1'b0; flags_clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_count",     count,     0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready",  in_ready,  1);
      check("rst_flags",     {flag_overflow, flag_underflow, flag_invalid}, 0);
      check("rst_out_data",  out_data,  0);
      rstn = 1'b1;

      // Order and latency: three back-to-back pushes with no pops.
      cyc(1, 5'd1, 32'h3F800000, 0, 0, 0, 0);
      check("lat_valid", out_valid, 1);
      check("lat_tag",   out_tag,   1);
      cyc(1, 5'd2, 32'h40000000, 0, 0, 0, 0);
      cyc(1, 5'd3, 32'h40400000, 0, 0, 0, 0);
      check("order_count", count, 3);
      idle(0);
      check("stall_tag", out_tag, 1);
      for (int i = 1; i <= 3; i++) begin
         check("order_tag", out_tag, i);
         idle(1);
      end
      check("order_empty", out_valid, 0);

      // Full and wrap-around.
      for (int i = 1; i <= 4; i++) cyc(1, 5'(i), 32'h1000 + i, 0, 0, 0, 0);
      check("full_in_ready", in_ready, 0);
      check("full_count",    count,    4);
      cyc(1, 5'd9, 32'h9999, 0, 0, 0, 0);        // ignored while full
      check("full_ignored", count, 4);
      cyc(1, 5'd9, 32'h9999, 0, 0, 1, 0);        // the pop happens, the push is still refused
      check("full_pop_count", count, 3);
      idle(1);
      check("wrap_count", count, 2);
      cyc(1, 5'd5, 32'h1005, 0, 0, 0, 0);
      cyc(1, 5'd6, 32'h1006, 0, 0, 0, 0);
      for (int i = 3; i <= 6; i++) begin
         check("wrap_tag", out_tag, i);
         idle(1);
      end

      // Simultaneous push and pop at count 2.
      cyc(1, 5'd10, 32'hA, 0, 0, 0, 0);
      cyc(1, 5'd11, 32'hB, 0, 0, 0, 0);
      check("sim_head", out_tag, 10);
      cyc(1, 5'd12, 32'hC, 0, 0, 1, 0);
      check("sim_count", count, 2);
      check("sim_tag_a", out_tag, 11);
      idle(1);
      check("sim_tag_b", out_tag, 12);
      idle(1);

      // Sticky flags.
      cyc(1, 5'd1, 32'h3F800000, 1, 0, 1, 0);
      check("flag_ovf_set", flag_overflow, 1);
      cyc(1, 5'd2, 32'h7FC00000, 0, 0, 1, 0);
      check("flag_inv_set", flag_invalid, 1);
      check("flag_unf_clr", flag_underflow, 0);
      idle(1);
      cyc(0, 5'd0, 32'h0, 0, 0, 1, 1);
      check("flags_cleared", {flag_overflow, flag_underflow, flag_invalid}, 3'b000);
      cyc(1, 5'd3, 32'h7FC00000, 1, 0, 0, 0);
      cyc(1, 5'd4, 32'h00000001, 0, 1, 1, 1);
      check("clr_push_flags", {flag_overflow, flag_underflow, flag_invalid}, 3'b010);
      idle(1);
      idle(1);
      // An infinity (mantissa zero) is not a NaN.
      cyc(1, 5'd5, 32'h7F800000, 0, 0, 1, 0);
      check("inf_not_nan", flag_invalid, 0);
      idle(1);

      // Reset in the middle of operation.
      for (int i = 0; i < 3; i++) cyc(1, 5'(20 + i), 32'h2000 + i, 0, 0, 0, 0);
      check("mid_count", count, 3);
      rstn = 1'b0;
      idle(0);
      check("mid_rst_count", count, 0);
      check("mid_rst_valid", out_valid, 0);
      rstn = 1'b1;
      cyc(1, 5'd30, 32'h3000, 0, 0, 0, 0);
      check("post_rst_tag", out_tag, 30);
      check("post_rst_count", count, 1);
      idle(1);
      idle(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
